// File: rtl/iterative_shifter_if.sv
// iterative_shifter_if
// Groups the request/response signals of the iterative shift unit.
//   Start       : request pulse from the control unit
//   Op          : 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   Operand     : value to shift
//   ShiftAmount : zero-extended shamt (only the low bits are honoured)
//   Result      : shifted value, valid while Done is high
//   Busy        : high while the shift is in progress
//   Done        : one-cycle completion pulse
// master drives the request side (control unit / testbench).
// slave is the shifter itself.
interface iterative_shifter_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Operand;
  logic [WIDTH-1:0] ShiftAmount;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, Operand, ShiftAmount,
    input  Result, Busy, Done
  );

  modport slave (
    input  Start, Op, Operand, ShiftAmount,
    output Result, Busy, Done
  );
endinterface

// File: rtl/iterative_shifter.sv
// iterative_shifter
// Multi-cycle shift unit for the ALU shift path. Performs SLL, SRL, SRA or
// ROTR one bit position per clock so the control unit can stall on Busy.
// Ports:
//   Clk   : system clock, rising-edge active
//   Reset : asynchronous, active-high reset
//   bus   : iterative_shifter_if slave modport (Start/Op/Operand/ShiftAmount
//           in, Result/Busy/Done out)
// Latency: Done appears N edges after the accepting edge, N = ShiftAmount[4:0].
module iterative_shifter #(
  parameter int WIDTH    = 32,
  parameter int AMT_BITS = 5
) (
  input logic               Clk,
  input logic               Reset,
  iterative_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [AMT_BITS-1:0] count_q, count_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    stepped;
  logic [AMT_BITS-1:0] amt;
  logic                accept;
  logic                lastStep;
  logic                unused_amt_hi;

  // Only the low shamt bits matter; the upper bits of the zero-extended
  // amount are deliberately dropped.
  assign amt           = bus.ShiftAmount[AMT_BITS-1:0];
  assign unused_amt_hi = ^bus.ShiftAmount[WIDTH-1:AMT_BITS];

  // A request is taken whenever no shift is in flight, which includes the
  // DONE cycle so back-to-back operations have no idle gap.
  assign accept   = bus.Start && (state_q != SHIFT);
  assign lastStep = (state_q == SHIFT) && (count_q == AMT_BITS'(1));

  // One-bit step of the work register for the latched operation.
  always_comb begin
    stepped = work_q;
    unique case (op_q)
      2'b00: stepped = {work_q[WIDTH-2:0], 1'b0};
      2'b01: stepped = {1'b0, work_q[WIDTH-1:1]};
      2'b10: stepped = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      2'b11: stepped = {work_q[0], work_q[WIDTH-1:1]};
      default: stepped = work_q;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero shift amount skips SHIFT entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = (amt == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (lastStep) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state. Result is only written on the edge that enters
  // DONE, so it holds through IDLE and SHIFT until the next completion.
  always_comb begin
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    if (accept) begin
      work_d  = bus.Operand;
      count_d = amt;
      op_d    = bus.Op;
      if (amt == '0) begin
        result_d = bus.Operand;
      end
    end else if (state_q == SHIFT) begin
      work_d  = stepped;
      count_d = count_q - AMT_BITS'(1);
      if (lastStep) begin
        result_d = stepped;
      end
    end
  end

  // Datapath registers; reset clears everything so an aborted shift leaves
  // no trace on Result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    bus.Busy   = (state_q == SHIFT);
    bus.Done   = (state_q == DONE);
    bus.Result = result_q;
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter
// Self-checking bench for iterative_shifter: a table of directed vectors,
// randomized operations checked against an arithmetic reference, and
// hand-written sequences for reset abort, ignored Start and back-to-back use.
module tb_iterative_shifter;

  logic Clk = 1'b0;
  logic Reset;

  iterative_shifter_if #(.WIDTH(32)) bus ();

  iterative_shifter #(
    .WIDTH   (32),
    .AMT_BITS(5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [31:0] amt;
    logic [31:0] expResult;
    int          expLatency;
  } vec_t;

  vec_t        vecTable [8];
  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [31:0] lastResult     = 32'h0;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: shift by amount modulo 32 using plain operators; rotate is
  // taken as a window out of the value concatenated with itself.
  function automatic logic [31:0] refShift(input logic [1:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] amt);
    int          n;
    logic [63:0] dbl;
    n   = int'(amt % 32);
    dbl = {x, x};
    case (op)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return 32'($signed(x) >>> n);
      default: return dbl[n +: 32];
    endcase
  endfunction

  // Drive a request on the falling edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] operand,
                               input logic [31:0] amt);
    @(negedge Clk);
    bus.Op          = op;
    bus.Operand     = operand;
    bus.ShiftAmount = amt;
    bus.Start       = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Sample once per cycle (k = edges since the reference edge) until Done.
  task automatic waitDone(input int maxCycles, output int latency,
                          output int busyCycles, output bit timedOut);
    latency    = 0;
    busyCycles = 0;
    timedOut   = 1'b1;
    for (int k = 0; k <= maxCycles; k++) begin
      if (k > 0) begin
        @(posedge Clk);
        #1;
      end
      if (bus.Done === 1'b1) begin
        latency  = k;
        timedOut = 1'b0;
        break;
      end
      if (bus.Busy === 1'b1) busyCycles++;
    end
  endtask

  task automatic reportTimeout(input string name);
    vectorsApplied++;
    miscompares++;
    $display("[TB] FAIL %s: Done never seen, expected within 40 cycles", name);
  endtask

  task automatic runAndCheck(input string name, input logic [1:0] op,
                             input logic [31:0] operand, input logic [31:0] amt,
                             input logic [31:0] expResult, input int expLatency);
    int lat, busyCnt;
    bit timedOut;
    applyStimulus(op, operand, amt);
    if (expLatency > 0) checkOutput({name, ".hold"}, bus.Result, lastResult);
    waitDone(40, lat, busyCnt, timedOut);
    if (timedOut) begin
      reportTimeout(name);
    end else begin
      checkOutput({name, ".result"}, bus.Result, expResult);
      checkOutput({name, ".latency"}, lat, expLatency);
      checkOutput({name, ".busyCycles"}, busyCnt, expLatency);
      checkOutput({name, ".busyAtDone"}, {31'b0, bus.Busy}, 32'h0);
    end
    lastResult = expResult;
  endtask

  initial begin
    int          lat, busyCnt, doneCount;
    bit          timedOut;
    logic [1:0]  rOp;
    logic [31:0] rOperand, rAmt;

    vecTable[0] = '{2'b00, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 4};
    vecTable[1] = '{2'b10, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 31};
    vecTable[2] = '{2'b01, 32'h8000_0000, 32'd31,        32'h0000_0001, 31};
    vecTable[3] = '{2'b11, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 0};
    vecTable[4] = '{2'b11, 32'h0000_0001, 32'd1,         32'h8000_0000, 1};
    vecTable[5] = '{2'b10, 32'h7000_0000, 32'd4,         32'h0700_0000, 4};
    vecTable[6] = '{2'b11, 32'h1234_5678, 32'h0000_0028, 32'h7812_3456, 8};
    vecTable[7] = '{2'b00, 32'hFFFF_FFFF, 32'd31,        32'h8000_0000, 31};

    bus.Start       = 1'b0;
    bus.Op          = 2'b00;
    bus.Operand     = 32'h0;
    bus.ShiftAmount = 32'h0;
    Reset           = 1'b1;
    #1;
    checkOutput("reset.busy", {31'b0, bus.Busy}, 32'h0);
    checkOutput("reset.done", {31'b0, bus.Done}, 32'h0);
    checkOutput("reset.result", bus.Result, 32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecTable[i].op, vecTable[i].operand,
                  vecTable[i].amt, vecTable[i].expResult, vecTable[i].expLatency);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      rOp      = 2'($urandom_range(0, 3));
      rOperand = $urandom;
      rAmt     = $urandom;
      runAndCheck($sformatf("rand%0d", i), rOp, rOperand, rAmt,
                  refShift(rOp, rOperand, rAmt), int'(rAmt % 32));
    end

    // Start pulsed mid-shift with different inputs must be ignored.
    applyStimulus(2'b00, 32'h0000_0001, 32'd8);
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    @(negedge Clk);
    bus.Op          = 2'b11;
    bus.Operand     = 32'hFFFF_0000;
    bus.ShiftAmount = 32'd0;
    bus.Start       = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    checkOutput("ignore.busy", {31'b0, bus.Busy}, 32'h1);
    waitDone(40, lat, busyCnt, timedOut);
    if (timedOut) begin
      reportTimeout("ignore");
    end else begin
      checkOutput("ignore.result", bus.Result, refShift(2'b00, 32'h1, 32'd8));
      checkOutput("ignore.latency", lat + 3, 8);
    end

    // Start held high: no effect during SHIFT, re-triggers in DONE.
    @(negedge Clk);
    bus.Op          = 2'b01;
    bus.Operand     = 32'h0000_00F0;
    bus.ShiftAmount = 32'd3;
    bus.Start       = 1'b1;
    @(posedge Clk);
    #1;
    bus.Op          = 2'b00;
    bus.Operand     = 32'h0000_0001;
    bus.ShiftAmount = 32'd2;
    waitDone(40, lat, busyCnt, timedOut);
    if (timedOut) begin
      reportTimeout("b2bA");
    end else begin
      checkOutput("b2bA.result", bus.Result, 32'h0000_001E);
      checkOutput("b2bA.latency", lat, 3);
    end
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    waitDone(40, lat, busyCnt, timedOut);
    if (timedOut) begin
      reportTimeout("b2bB");
    end else begin
      checkOutput("b2bB.result", bus.Result, 32'h0000_0004);
      checkOutput("b2bB.latency", lat, 2);
      checkOutput("b2bB.busyCycles", busyCnt, 2);
    end
    @(posedge Clk);
    #1;
    checkOutput("b2bB.doneDrops", {31'b0, bus.Done}, 32'h0);
    lastResult = 32'h0000_0004;

    // Reset in the middle of a long shift aborts it silently.
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd20);
    repeat (5) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("abort.busy", {31'b0, bus.Busy}, 32'h0);
    checkOutput("abort.done", {31'b0, bus.Done}, 32'h0);
    checkOutput("abort.result", bus.Result, 32'h0);
    @(negedge Clk);
    Reset      = 1'b0;
    lastResult = 32'h0;
    doneCount  = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk);
      #1;
      if (bus.Done === 1'b1) doneCount++;
    end
    checkOutput("abort.noLateDone", doneCount, 0);
    runAndCheck("postReset", 2'b00, 32'h0000_0003, 32'd1, 32'h0000_0006, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
